fetch_unit: RTL and testbench

- Consumes the PC/nPC pair produced by the next-instruction stage.
- Issues one instruction-memory read per PC and hands the fetched word plus its PC/nPC to decode over a valid/ready handshake.
- Drives if_ready back to the next-instruction stage so the PC pair advances only when a fetch is accepted by memory.
- Handles redirect flushes by discarding in-flight or held fetches.

---
 rtl/fetch_unit_if.sv | 53 +++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the signals the fetch unit exchanges with its neighbours:
//   - next-instruction stage : pc_in, npc_in (to fetch), if_ready (from fetch)
//   - redirect               : flush (to fetch)
//   - instruction memory     : mem_req_valid/addr (from fetch), mem_req_ready,
//                              mem_resp_valid/data/err (to fetch)
//   - decode stage           : id_valid/inst/pc/npc/fault (from fetch),
//                              id_ready (to fetch)
// modport master : the fetch unit side.
// modport slave  : the environment side (next-PC stage, memory, decode).
//
// Handshake semantics: a request/entry transfers on a clock edge where both
// valid and ready are high. A producer holding valid keeps its payload stable
// until the transfer. The memory response has no ready: it is taken whenever
// valid is high. if_ready is the memory request handshake itself, so the PC
// pair advances exactly when the fetch of pc_in is accepted.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int PC_SIZE   = 32,
  parameter int INST_SIZE = 32
);
  logic [PC_SIZE-1:0]   pc_in;
  logic [PC_SIZE-1:0]   npc_in;
  logic                 if_ready;
  logic                 flush;
  logic                 mem_req_valid;
  logic [PC_SIZE-1:0]   mem_req_addr;
  logic                 mem_req_ready;
  logic                 mem_resp_valid;
  logic [INST_SIZE-1:0] mem_resp_data;
  logic                 mem_resp_err;
  logic                 id_valid;
  logic [INST_SIZE-1:0] id_inst;
  logic [PC_SIZE-1:0]   id_pc;
  logic [PC_SIZE-1:0]   id_npc;
  logic                 id_fault;
  logic                 id_ready;

  modport master (
    input  pc_in, npc_in, flush, mem_req_ready, mem_resp_valid,
           mem_resp_data, mem_resp_err, id_ready,
    output if_ready, mem_req_valid, mem_req_addr, id_valid, id_inst,
           id_pc, id_npc, id_fault
  );

  modport slave (
    output pc_in, npc_in, flush, mem_req_ready, mem_resp_valid,
           mem_resp_data, mem_resp_err, id_ready,
    input  if_ready, mem_req_valid, mem_req_addr, id_valid, id_inst,
           id_pc, id_npc, id_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Issues one instruction-memory read per PC from the next-instruction stage,
// and hands the fetched word with its PC/nPC to decode. At most one memory
// request is outstanding. A redirect (flush) squashes an in-flight or held
// fetch.
//
// Ports:
//   clk      : clock
//   reset    : asynchronous, active-high reset
//   bus      : fetch_unit_if.master (PC pair, memory request/response,
//              decode entry, flush)
//   state_o  : current FSM state, for debug/observation
//
// States:
//   IDLE : one cycle after reset, then REQ
//   REQ  : present pc_in to memory; on acceptance capture PC pair -> WAIT
//   WAIT : await response; deliver -> OUT, or squash -> REQ / DROP
//   DROP : flushed while waiting; swallow the response -> REQ
//   OUT  : hold decode entry until accepted or flushed -> REQ
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_SIZE   = 32,
  parameter int INST_SIZE = 32
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  output logic [2:0]   state_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]           state_q,    state_d;
  logic [PC_SIZE-1:0]   pend_pc_q,  pend_pc_d;
  logic [PC_SIZE-1:0]   pend_npc_q, pend_npc_d;
  logic                 id_valid_q, id_valid_d;
  logic [INST_SIZE-1:0] id_inst_q,  id_inst_d;
  logic [PC_SIZE-1:0]   id_pc_q,    id_pc_d;
  logic [PC_SIZE-1:0]   id_npc_q,   id_npc_d;
  logic                 id_fault_q, id_fault_d;

  logic in_req;
  logic req_valid;
  logic req_fire;

  // A flush in REQ suppresses the request so the stale PC is never fetched;
  // the redirected PC is presented on the following cycle.
  assign in_req    = (state_q == S_REQ);
  assign req_valid = in_req && !bus.flush;
  assign req_fire  = req_valid && bus.mem_req_ready;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = in_req ? bus.pc_in : '0;
  assign bus.if_ready      = req_fire;

  assign bus.id_valid = id_valid_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_npc   = id_npc_q;
  assign bus.id_fault = id_fault_q;

  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    pend_npc_d = pend_npc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_npc_d   = id_npc_q;
    id_fault_d = id_fault_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (req_fire) begin
          pend_pc_d  = bus.pc_in;
          pend_npc_d = bus.npc_in;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          if (bus.flush) begin
            state_d = S_REQ;
          end else begin
            // A faulting fetch delivers a zero word so garbage never
            // reaches decode.
            id_inst_d  = bus.mem_resp_err ? '0 : bus.mem_resp_data;
            id_fault_d = bus.mem_resp_err;
            id_pc_d    = pend_pc_q;
            id_npc_d   = pend_npc_q;
            id_valid_d = 1'b1;
            state_d    = S_OUT;
          end
        end else if (bus.flush) begin
          state_d = S_DROP;
        end
      end

      S_DROP: begin
        if (bus.mem_resp_valid) begin
          state_d = S_REQ;
        end
      end

      S_OUT: begin
        // Flush wins over id_ready: the entry is withdrawn either way.
        if (bus.flush || bus.id_ready) begin
          id_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_pc_q  <= '0;
      pend_npc_q <= '0;
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
      id_npc_q   <= '0;
      id_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      pend_npc_q <= pend_npc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_npc_q   <= id_npc_d;
      id_fault_q <= id_fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Inputs change on the falling edge, outputs
// are sampled 1 ns later. Expected decode entries {fault, npc, pc, inst} are
// pushed when the bench returns a memory response that should be delivered,
// and popped when decode accepts an entry.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PW = 32;
  localparam int IW = 32;
  localparam int EW = 1 + PW + PW + IW;

  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_SIZE(PW), .INST_SIZE(IW)) bus ();

  fetch_unit #(.PC_SIZE(PW), .INST_SIZE(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .state_o (state_o)
  );

  // ---------------- scoreboard / counters ----------------
  logic [EW-1:0] exp_q[$];
  int checks      = 0;
  int errors      = 0;
  int hs_count    = 0;
  int dlv_count   = 0;
  int stray_count = 0;
  int hs_before   = 0;

  // Event monitors: memory handshakes, accepted decode entries, and
  // responses arriving while no request is outstanding.
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.mem_req_valid && bus.mem_req_ready) hs_count++;
      if (bus.id_valid && bus.id_ready && !bus.flush) dlv_count++;
      if (bus.mem_resp_valid && state_o != S_WAIT && state_o != S_DROP)
        stray_count++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic f,
                                         input logic [PW-1:0] npc,
                                         input logic [PW-1:0] pc,
                                         input logic [IW-1:0] inst);
    return {f, npc, pc, inst};
  endfunction

  task automatic check_accept(input string tag);
    logic [EW-1:0] obs;
    obs = {bus.id_fault, bus.id_npc, bus.id_pc, bus.id_inst};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0x%0h expected=none", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_id_valid"},  bus.id_valid,      0);
    chk({tag, "_id_inst"},   bus.id_inst,       0);
    chk({tag, "_id_pc"},     bus.id_pc,         0);
    chk({tag, "_id_npc"},    bus.id_npc,        0);
    chk({tag, "_id_fault"},  bus.id_fault,      0);
    chk({tag, "_if_ready"},  bus.if_ready,      0);
    chk({tag, "_req_valid"}, bus.mem_req_valid, 0);
    chk({tag, "_req_addr"},  bus.mem_req_addr,  0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset              = 1'b1;
    bus.pc_in          = 32'h1000;
    bus.npc_in         = 32'h1004;
    bus.flush          = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.mem_resp_err   = 1'b0;
    bus.id_ready       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");

    // Basic fetch: release reset, IDLE one cycle, then REQ
    @(negedge clk); reset = 1'b0;
    #1 chk("idle_no_req", bus.mem_req_valid, 0);
    @(negedge clk);
    #1 chk("t1_req_valid", bus.mem_req_valid, 1);
    chk("t1_req_addr", bus.mem_req_addr, 32'h1000);
    chk("t1_if_ready", bus.if_ready, 1);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0100_0000;
    bus.pc_in = 32'h1004; bus.npc_in = 32'h1008;
    exp_q.push_back(pack(1'b0, 32'h1004, 32'h1000, 32'h0100_0000));
    #1 chk("t1_if_ready_one_cycle", bus.if_ready, 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.id_ready = 1'b1;
    #1 chk("t1_id_valid", bus.id_valid, 1);
    check_accept("t1_entry");
    chk("t1_no_req_in_out", bus.mem_req_valid, 0);

    // Memory back-pressure for 3 cycles
    @(negedge clk);
    bus.id_ready = 1'b0; bus.mem_req_ready = 1'b0;
    hs_before = hs_count;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1 chk("t2_stall_req_valid", bus.mem_req_valid, 1);
      chk("t2_stall_addr", bus.mem_req_addr, 32'h1004);
      chk("t2_stall_if_ready", bus.if_ready, 0);
    end
    chk("t2_id_valid_low", bus.id_valid, 0);
    @(negedge clk); bus.mem_req_ready = 1'b1;
    #1 chk("t2_if_ready", bus.if_ready, 1);

    // Decode back-pressure for 4 cycles
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h2222_3333;
    bus.pc_in = 32'h1008; bus.npc_in = 32'h100C;
    exp_q.push_back(pack(1'b0, 32'h1008, 32'h1004, 32'h2222_3333));
    #1 chk("t2_one_handshake", hs_count - hs_before, 1);
    chk("t3_wait_no_req", bus.mem_req_valid, 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1 chk("t3_hold_valid", bus.id_valid, 1);
      chk("t3_hold_inst", bus.id_inst, 32'h2222_3333);
      chk("t3_hold_pc", bus.id_pc, 32'h1004);
      chk("t3_hold_npc", bus.id_npc, 32'h1008);
      chk("t3_hold_no_req", bus.mem_req_valid, 0);
    end
    @(negedge clk); bus.id_ready = 1'b1;
    #1 check_accept("t3_entry");
    chk("t3_accept_no_req", bus.mem_req_valid, 0);
    @(negedge clk); bus.id_ready = 1'b0;
    #1 chk("t3_next_req_valid", bus.mem_req_valid, 1);
    chk("t3_next_req_addr", bus.mem_req_addr, 32'h1008);
    chk("t3_id_valid_low", bus.id_valid, 0);

    // Flush in WAIT, response two cycles later -> DROP
    @(negedge clk);
    bus.flush = 1'b1; bus.pc_in = 32'h2000; bus.npc_in = 32'h2004;
    #1 chk("t4_flush_if_ready", bus.if_ready, 0);
    @(negedge clk); bus.flush = 1'b0;
    #1 chk("t4_drop_no_req", bus.mem_req_valid, 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hBAD0_BAD0;
    #1 chk("t4_drop_id_valid", bus.id_valid, 0);
    chk("t4_drop_still_no_req", bus.mem_req_valid, 0);
    @(negedge clk); bus.mem_resp_valid = 1'b0;
    #1 chk("t4_discard_id_valid", bus.id_valid, 0);
    chk("t4_redirect_req", bus.mem_req_valid, 1);
    chk("t4_redirect_addr", bus.mem_req_addr, 32'h2000);

    // Flush coincident with response in WAIT
    @(negedge clk);
    bus.flush = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h5555_5555;
    bus.pc_in = 32'h3000; bus.npc_in = 32'h3004;
    #1 chk("t5_flush_if_ready", bus.if_ready, 0);
    @(negedge clk); bus.flush = 1'b0; bus.mem_resp_valid = 1'b0;
    #1 chk("t5_no_delivery", bus.id_valid, 0);
    chk("t5_req_valid", bus.mem_req_valid, 1);
    chk("t5_req_addr", bus.mem_req_addr, 32'h3000);
    // Flush in OUT together with id_ready
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h6666_6666;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.flush = 1'b1; bus.id_ready = 1'b1;
    bus.pc_in = 32'h4000; bus.npc_in = 32'h4004;
    #1 chk("t5_out_valid", bus.id_valid, 1);
    chk("t5_out_no_req", bus.mem_req_valid, 0);
    @(negedge clk); bus.flush = 1'b0; bus.id_ready = 1'b0;
    #1 chk("t5_out_flushed", bus.id_valid, 0);
    chk("t5_out_req", bus.mem_req_valid, 1);
    chk("t5_out_addr", bus.mem_req_addr, 32'h4000);
    chk("t5_deliveries", dlv_count, 2);

    // Access fault response
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_err = 1'b1;
    bus.mem_resp_data = 32'hDEAD_BEEF;
    bus.pc_in = 32'h4008; bus.npc_in = 32'h400C;
    exp_q.push_back(pack(1'b1, 32'h4004, 32'h4000, 32'h0));
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0; bus.id_ready = 1'b1;
    #1 check_accept("t6_err_entry");
    chk("t6_fault", bus.id_fault, 1);
    @(negedge clk); bus.id_ready = 1'b0;
    #1 chk("t6_req_after", bus.if_ready, 1);

    // Async reset in the middle of WAIT
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("t7_async");
    @(negedge clk);
    reset = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h7777_7777;
    #1 chk("t7_idle_id_valid", bus.id_valid, 0);
    @(negedge clk); bus.mem_resp_valid = 1'b0;
    #1 chk("t7_stray_ignored", bus.id_valid, 0);
    chk("t7_req_valid", bus.mem_req_valid, 1);
    chk("t7_req_addr", bus.mem_req_addr, 32'h4008);
    chk("t7_stray_flagged", stray_count, 1);

    // Normal fetch after recovery
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1234_5678;
    bus.pc_in = 32'h400C; bus.npc_in = 32'h4010;
    exp_q.push_back(pack(1'b0, 32'h400C, 32'h4008, 32'h1234_5678));
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.id_ready = 1'b1;
    #1 check_accept("t8_entry");
    @(negedge clk); bus.id_ready = 1'b0;
    #1 chk("t8_deliveries", dlv_count, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
